// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH clocks,
// with the carry held in a flop between bit steps.

// Single-bit full adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;

  fulladder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  // Result shift: new sum bit enters at the MSB (written to also cover WIDTH=1).
  always_comb begin
    acc_nxt            = acc >> 1;
    acc_nxt[WIDTH-1]   = s_bit;
  end

  // Controller, datapath shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= c_bit;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= acc_nxt;
            cout  <= c_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8, 1 and 32 with a result scoreboard.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start1, cin1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
  logic        start32, cin32, busy32, done32, cout32;
  logic [31:0] a32, b32, sum32;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int dn8 = 0, dn1 = 0, dn32 = 0;
  logic [8:0]  q8[$];
  logic [1:0]  q1[$];
  logic [32:0] q32[$];
  logic [8:0]  last8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    bit         rep;
  } vec_t;
  vec_t vecs[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      logic [8:0] e;
      dn8++;
      if (q8.size() == 0) chk("done8_unexpected", 64'(1), 64'(0));
      else begin
        e = q8.pop_front();
        chk("sum8", 64'(sum8), 64'(e[7:0]));
        chk("cout8", 64'(cout8), 64'(e[8]));
      end
    end
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      logic [1:0] e;
      dn1++;
      if (q1.size() == 0) chk("done1_unexpected", 64'(1), 64'(0));
      else begin
        e = q1.pop_front();
        chk("sum1_cout1", 64'({cout1, sum1}), 64'(e));
      end
    end
    if (rst_n === 1'b1 && done32 === 1'b1) begin
      logic [32:0] e;
      dn32++;
      if (q32.size() == 0) chk("done32_unexpected", 64'(1), 64'(0));
      else begin
        e = q32.pop_front();
        chk("sum32_cout32", 64'({cout32, sum32}), 64'(e));
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic eco, input bit rep);
    int lat;
    int d0;
    @(negedge clk);
    d0 = dn8;
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    q8.push_back({eco, es});
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    chk("busy8_after_accept", 64'(busy8), 64'(1));
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        chk("sum8_hold_run", 64'({cout8, sum8}), 64'(last8));
        chk("busy8_run", 64'(busy8), 64'(1));
      end
      if (rep && lat == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
      if (rep && lat == 4) start8 = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency8", 64'(lat), 64'(8));
    chk("busy8_in_done", 64'(busy8), 64'(0));
    last8 = {eco, es};
    @(negedge clk);
    chk("done8_one_cycle", 64'(done8), 64'(0));
    chk("sum8_held_after", 64'({cout8, sum8}), 64'({eco, es}));
    #1;
    chk("done8_count", 64'(dn8 - d0), 64'(1));
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int lat;
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    q1.push_back(2'(a) + 2'(b) + 2'(c));
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency1", 64'(lat), 64'(1));
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic c);
    int lat;
    @(negedge clk);
    start32 = 1'b1; a32 = a; b32 = b; cin32 = c;
    q32.push_back(33'(a) + 33'(b) + 33'(c));
    @(negedge clk);
    start32 = 1'b0;
    lat = 0;
    while (done32 !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("latency32", 64'(lat), 64'(32));
  endtask

  initial begin
    int n;
    int tprev;
    int d0;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    start32 = 0; a32 = 0; b32 = 0; cin32 = 0;
    last8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'(0));
    chk("rst_done8", 64'(done8), 64'(0));
    chk("rst_sum8_cout8", 64'({cout8, sum8}), 64'(0));
    chk("rst_sum32_busy32", 64'({busy32, cout32, sum32}), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].rep);

    // start held high: back-to-back results, new request wins in DONE cycle
    @(negedge clk);
    d0 = dn8;
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    repeat (3) q8.push_back(9'h101);
    n = 0; tprev = 0;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        n++;
        if (n > 1) chk("b2b_gap", 64'(cyc - tprev), 64'(9));
        tprev = cyc;
        if (n == 3) start8 = 1'b0;
        else begin
          @(negedge clk);
          chk("b2b_busy_after_done", 64'({busy8, done8}), 64'(2'b10));
          chk("b2b_sum_held", 64'({cout8, sum8}), 64'(9'h101));
        end
      end
    end
    chk("b2b_done_seen", 64'(n), 64'(3));
    repeat (3) @(negedge clk);
    chk("b2b_idle", 64'(busy8), 64'(0));
    chk("b2b_count", 64'(dn8 - d0), 64'(3));
    last8 = 9'h101;

    // reset mid-RUN aborts with no result
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h21; cin8 = 1'b0;
    q8.push_back(9'h07B);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy8", 64'(busy8), 64'(0));
    chk("abort_done8", 64'(done8), 64'(0));
    chk("abort_sum8_cout8", 64'({cout8, sum8}), 64'(0));
    q8.delete();
    last8 = '0;
    d0 = dn8;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(dn8 - d0), 64'(0));
    op8(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0);

    // parameter corners with random operands
    for (int i = 0; i < 8; i++) op1(1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 6; i++) op32(32'($urandom), 32'($urandom), 1'($urandom));
    op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    repeat (3) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));
    chk("q32_drained", 64'(q32.size()), 64'(0));
    chk("dn1_count", 64'(dn1), 64'(8));
    chk("dn32_count", 64'(dn32), 64'(7));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
